// File: rtl/npu_mem_pkg.sv
// Shared constants, row type and controller state encoding for the output memory.
// ST_CLEAR exists only when OUT_MEM_CTRL_CLEAR_EN is defined.
package npu_mem_pkg;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int RD_LAT = 2;

  typedef logic [LANES-1:0][DATA_W-1:0] row_t;

`ifdef OUT_MEM_CTRL_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_CLEAR} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
`endif
endpackage

// File: rtl/out_mem_rd_pipe.sv
// Tracks read tokens in flight so each accepted read yields one rd_valid.
// Latency DEPTH cycles from in_vld to out_vld; no backpressure, one token per cycle.
// Async reset drops every token in flight.
module out_mem_rd_pipe #(
  parameter int DEPTH = npu_mem_pkg::RD_LAT + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  output logic out_vld
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= (sr << 1) | DEPTH'(in_vld);
  end

  assign out_vld = sr[DEPTH-1];
endmodule

// File: rtl/out_mem_ctrl.sv
// Output-memory controller: streams write frames into LANES banks and serves reads.
// Writes reach the RAM one cycle after acceptance, reads return RD_LAT+1 cycles after rd_ack.
// Write/read share the port with round-robin arbitration; OUT_MEM_CTRL_CLEAR_EN adds zero-fill.
module out_mem_ctrl #(
  parameter int ADDR_W = npu_mem_pkg::ADDR_W,
  parameter int DATA_W = npu_mem_pkg::DATA_W,
  parameter int LANES  = npu_mem_pkg::LANES,
  parameter int RD_LAT = npu_mem_pkg::RD_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W:0]         frame_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_W*LANES-1:0] wr_data,
  input  logic                    rd_req,
  output logic                    rd_ack,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_valid,
  output logic [DATA_W*LANES-1:0] rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W*LANES-1:0] mem_data,
`ifdef OUT_MEM_CTRL_CLEAR_EN
  input  logic                    clear_req,
`endif
  input  logic [DATA_W*LANES-1:0] mem_q
);
  import npu_mem_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ROW = {ADDR_W{1'b1}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt, len;
  logic              wr_turn;
  logic              wr_acc, conflict, wr_last, frame_go;

  assign conflict = (state == ST_RUN) && wr_valid && rd_req;
  assign wr_acc   = wr_valid && wr_ready;
  assign wr_last  = (cnt + 1'b1) == len;
  assign frame_go = (state == ST_IDLE) && start && (frame_len != '0);

  // wr_turn names who wins the next conflict; the loser of one conflict wins the next.
  always_comb begin
    wr_ready = 1'b0;
    rd_ack   = 1'b0;
    if (!rst) begin
      wr_ready = (state == ST_RUN) && (!rd_req || wr_turn);
      rd_ack   = rd_req && ((state == ST_IDLE) || (state == ST_DONE) ||
                            ((state == ST_RUN) && !(wr_valid && wr_turn)));
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (frame_len != '0) state_nxt = ST_RUN;
          else                 done      = 1'b1;
        end
`ifdef OUT_MEM_CTRL_CLEAR_EN
        else if (clear_req) state_nxt = ST_CLEAR;
`endif
      end
      ST_RUN:  if (wr_acc && wr_last) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
`ifdef OUT_MEM_CTRL_CLEAR_EN
      ST_CLEAR: if (ptr == LAST_ROW) state_nxt = ST_DONE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
    done = done && !rst;
  end

`ifdef OUT_MEM_CTRL_CLEAR_EN
  assign busy = (state == ST_RUN) || (state == ST_CLEAR);
`else
  assign busy = (state == ST_RUN);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      len      <= '0;
      wr_turn  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= 1'b0;
      if (conflict) wr_turn <= !wr_turn;
      if (frame_go) begin
        ptr <= base_addr;
        cnt <= '0;
        len <= frame_len;
      end
      if (wr_acc) begin
        mem_we   <= 1'b1;
        mem_addr <= ptr;
        mem_data <= wr_data;
        ptr      <= ptr + 1'b1;
        cnt      <= cnt + 1'b1;
      end else if (rd_ack) begin
        mem_addr <= rd_addr;
      end
`ifdef OUT_MEM_CTRL_CLEAR_EN
      if ((state == ST_IDLE) && !start && clear_req) ptr <= '0;
      if (state == ST_CLEAR) begin
        mem_we   <= 1'b1;
        mem_addr <= ptr;
        mem_data <= '0;
        ptr      <= ptr + 1'b1;
      end
`endif
    end
  end

  out_mem_rd_pipe #(.DEPTH(RD_LAT + 1)) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_ack),
    .out_vld (rd_valid)
  );

  // RAM output is already aligned with the returning token.
  assign rd_data = mem_q;
endmodule
